sevenseg_frame_decoder: RTL

Reads the six 7-segment drive buses (active-low, bit0=a … bit6=g) back into character codes. A stability filter qualifies each frame, and every new stable message is reported once over a valid/ready handshake. It is used as an on-chip display monitor and as a self-check partner for the display driver, so software and bench can read what the panel shows ("HAL900", "STOP").

---
 rtl/sevenseg_pkg.sv | 71 +++++++
 rtl/sevenseg_frame_decoder_if.sv | 24 ++
 rtl/sevenseg_char_decode.sv | 11 +
 rtl/sevenseg_frame_decoder.sv | 127 ++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared character codes, segment patterns and decode helpers for the
// seven-segment frame monitor.
package sevenseg_pkg;

  localparam int unsigned NUM_DIGITS = 6;

  localparam logic [4:0] CH_A     = 5'h0A;
  localparam logic [4:0] CH_H     = 5'h10;
  localparam logic [4:0] CH_L     = 5'h11;
  localparam logic [4:0] CH_P     = 5'h12;
  localparam logic [4:0] CH_T     = 5'h13;
  localparam logic [4:0] CH_UNK   = 5'h1E;
  localparam logic [4:0] CH_BLANK = 5'h1F;

  // Active-low patterns, bit6 = g ... bit0 = a
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_9_ALT = 7'b0011000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_H     = 7'b0001001;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_T     = 7'b0000111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef logic [5*NUM_DIGITS-1:0] frame_t;

  localparam frame_t FRAME_BLANK = {NUM_DIGITS{CH_BLANK}};

  function automatic logic [4:0] seg_to_char(input logic [6:0] seg);
    logic [4:0] code;
    case (seg)
      SEG_0:            code = 5'h00;
      SEG_1:            code = 5'h01;
      SEG_2:            code = 5'h02;
      SEG_3:            code = 5'h03;
      SEG_4:            code = 5'h04;
      SEG_5:            code = 5'h05;
      SEG_6:            code = 5'h06;
      SEG_7:            code = 5'h07;
      SEG_8:            code = 5'h08;
      SEG_9, SEG_9_ALT: code = 5'h09;
      SEG_A:            code = CH_A;
      SEG_H:            code = CH_H;
      SEG_L:            code = CH_L;
      SEG_P:            code = CH_P;
      SEG_T:            code = CH_T;
      SEG_BLANK:        code = CH_BLANK;
      default:          code = CH_UNK;
    endcase
    return code;
  endfunction

  function automatic logic has_unknown(input frame_t frame);
    logic unk;
    unk = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (frame[5*i +: 5] == CH_UNK) unk = 1'b1;
    end
    return unk;
  endfunction

endpackage

// File: rtl/sevenseg_frame_decoder_if.sv
// Frame report channel: decoded characters offered under valid/ready.
interface sevenseg_frame_decoder_if;
  import sevenseg_pkg::*;

  logic   frm_valid;
  logic   frm_ready;
  frame_t frm_chars;
  logic   frm_unknown;

  modport master (
    output frm_valid,
    output frm_chars,
    output frm_unknown,
    input  frm_ready
  );

  modport slave (
    input  frm_valid,
    input  frm_chars,
    input  frm_unknown,
    output frm_ready
  );

endinterface

// File: rtl/sevenseg_char_decode.sv
// Combinational single-digit decoder: active-low segment pattern to character code.
module sevenseg_char_decode
  import sevenseg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [4:0] code_o
);

  assign code_o = seg_to_char(seg_i);

endmodule

// File: rtl/sevenseg_frame_decoder.sv
// Reads six segment buses back into characters, qualifies them with a stability
// filter and reports each new stable frame once over valid/ready.
module sevenseg_frame_decoder
  import sevenseg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned DROP_W        = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [6:0]               ss0,
  input  logic [6:0]               ss1,
  input  logic [6:0]               ss2,
  input  logic [6:0]               ss3,
  input  logic [6:0]               ss4,
  input  logic [6:0]               ss5,
  sevenseg_frame_decoder_if.master frm,
  output logic                     stable,
  output logic [DROP_W-1:0]        drop_count
);

  localparam logic [7:0] StableCnt = 8'(STABLE_CYCLES);
  localparam logic [7:0] AcceptCnt = 8'(STABLE_CYCLES - 1);

  logic [41:0]       raw, sample_q, sample_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              accept;
  frame_t            dec_frame;

  frame_t            out_q, out_d, latest_q, latest_d, target;
  logic              valid_q, valid_d, pend_q, pend_d, has_out_q, has_out_d;
  logic              unk_q, unk_d, xfer, fresh;
  logic [DROP_W-1:0] drop_q, drop_d;

  assign raw = {ss5, ss4, ss3, ss2, ss1, ss0};

  // Decode the held sample; it equals raw whenever accept fires.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
    sevenseg_char_decode u_dec (
      .seg_i  (sample_q[7*i +: 7]),
      .code_o (dec_frame[5*i +: 5])
    );
  end

  always_comb begin
    sample_d = sample_q;
    cnt_d    = cnt_q;
    if (raw != sample_q) begin
      sample_d = raw;
      cnt_d    = '0;
    end else if (cnt_q != StableCnt) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  assign accept = (raw == sample_q) && (cnt_q == AcceptCnt);
  assign stable = (cnt_q == StableCnt);

  always_comb begin
    out_d     = out_q;
    latest_d  = latest_q;
    valid_d   = valid_q;
    pend_d    = pend_q;
    has_out_d = has_out_q;
    drop_d    = drop_q;
    xfer      = valid_q && frm.frm_ready;
    // Compare against whatever was offered most recently, shown or queued.
    target    = pend_q ? latest_q : out_q;
    fresh     = accept && (!has_out_q || (dec_frame != target));
    if (fresh) begin
      has_out_d = 1'b1;
      if (!valid_q) begin
        out_d   = dec_frame;
        valid_d = 1'b1;
      end else if (xfer) begin
        if (pend_q) begin
          out_d    = latest_q;
          latest_d = dec_frame;
        end else begin
          out_d = dec_frame;
        end
      end else begin
        latest_d = dec_frame;
        pend_d   = 1'b1;
        if (pend_q && (drop_q != '1)) drop_d = drop_q + DROP_W'(1);
      end
    end else if (xfer) begin
      if (pend_q) begin
        out_d  = latest_q;
        pend_d = 1'b0;
      end else begin
        valid_d = 1'b0;
      end
    end
    unk_d = has_unknown(out_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q  <= '1;
      cnt_q     <= '0;
      out_q     <= FRAME_BLANK;
      latest_q  <= FRAME_BLANK;
      valid_q   <= 1'b0;
      pend_q    <= 1'b0;
      has_out_q <= 1'b0;
      unk_q     <= 1'b0;
      drop_q    <= '0;
    end else begin
      sample_q  <= sample_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      latest_q  <= latest_d;
      valid_q   <= valid_d;
      pend_q    <= pend_d;
      has_out_q <= has_out_d;
      unk_q     <= unk_d;
      drop_q    <= drop_d;
    end
  end

  assign frm.frm_valid   = valid_q;
  assign frm.frm_chars   = out_q;
  assign frm.frm_unknown = unk_q;
  assign drop_count      = drop_q;

endmodule
